// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback decoder.
package regfile_pkg;

  // Default register address width.
  localparam int ADDR_W = 5;

  // Default index of the hard-wired zero register.
  localparam int ZERO_REG = 31;

  // Number of bits needed to hold a population count of n one-hot bits (0..n).
  function automatic int onehot_count(input int n);
    int width;
    width = 1;
    while ((2 ** width) < (n + 1)) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/regfile_wb_decoder_onehot.sv
// Combinational address-to-one-hot decoder with an enable gate.
module onehot_enable_decoder #(
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0]      sel,
  input  logic                   enable,
  output logic [2**ADDR_W-1:0]   out
);

  // Drive exactly one bit when enabled, nothing otherwise.
  always_comb begin
    out = '0;
    if (enable) begin
      out[sel] = 1'b1;
    end else begin
      out = '0;
    end
  end

endmodule

// File: rtl/regfile_wb_decoder.sv
// Register-file write-port decoder with a busy scoreboard for WAW stalls
// and RAW hazard flags on two read ports.
module regfile_wb_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG,
  parameter int ZERO_EN  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_valid,
  input  logic [ADDR_W-1:0]    iss_addr,
  output logic                 iss_ready,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_addr,
  output logic [NUM_REGS-1:0]  we,
  input  logic [ADDR_W-1:0]    rd_a_addr,
  input  logic [ADDR_W-1:0]    rd_b_addr,
  output logic                 rd_a_hazard,
  output logic                 rd_b_hazard,
  output logic [NUM_REGS-1:0]  busy,
  output logic [ADDR_W:0]      busy_cnt,
  output logic                 wb_err
);

  localparam int CNT_W = onehot_count(NUM_REGS);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic ZERO_ON = (ZERO_EN != 0);

  logic                iss_zero;
  logic                wb_zero;
  logic                rd_a_zero;
  logic                rd_b_zero;
  logic                iss_take;
  logic                wb_take;
  logic                cnt_inc;
  logic                cnt_dec;
  logic [NUM_REGS-1:0] wb_onehot;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] busy_next;

  // Zero-register masking, acceptance and error qualification.
  always_comb begin
    iss_zero    = ZERO_ON && (iss_addr == ZERO_ADDR);
    wb_zero     = ZERO_ON && (wb_addr == ZERO_ADDR);
    rd_a_zero   = ZERO_ON && (rd_a_addr == ZERO_ADDR);
    rd_b_zero   = ZERO_ON && (rd_b_addr == ZERO_ADDR);
    // Stall only on a pending write; a same-cycle writeback does not bypass.
    iss_ready   = !busy[iss_addr] || iss_zero;
    iss_take    = iss_valid && iss_ready && !iss_zero;
    wb_take     = wb_valid && !wb_zero;
    rd_a_hazard = busy[rd_a_addr] && !rd_a_zero;
    rd_b_hazard = busy[rd_b_addr] && !rd_b_zero;
  end

  onehot_enable_decoder #(.ADDR_W(ADDR_W)) u_wb_dec (
    .sel    (wb_addr),
    .enable (wb_take),
    .out    (wb_onehot)
  );

  onehot_enable_decoder #(.ADDR_W(ADDR_W)) u_iss_dec (
    .sel    (iss_addr),
    .enable (iss_take),
    .out    (set_vec)
  );

  // Next scoreboard and count deltas; a clear wins over a set on the same bit
  // so the count only moves when a bit actually changes.
  always_comb begin
    busy_next = (busy | set_vec) & ~wb_onehot;
    cnt_inc   = iss_take && !(wb_take && (wb_addr == iss_addr));
    cnt_dec   = wb_take && busy[wb_addr];
  end

  // Registered write enable, scoreboard, busy count and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      we       <= '0;
      busy     <= '0;
      busy_cnt <= '0;
      wb_err   <= 1'b0;
    end else begin
      we   <= wb_onehot;
      busy <= busy_next;
      if (cnt_inc && !cnt_dec) begin
        busy_cnt <= busy_cnt + CNT_W'(1);
      end else if (cnt_dec && !cnt_inc) begin
        busy_cnt <= busy_cnt - CNT_W'(1);
      end else begin
        busy_cnt <= busy_cnt;
      end
      if (wb_take && !busy[wb_addr]) begin
        wb_err <= 1'b1;
      end else begin
        wb_err <= wb_err;
      end
    end
  end

endmodule
